// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port, fixed-latency memory between instruction fetch and data access.
// Data accesses win unless fetch has been starved; one transaction is in flight at a time.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 64,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned INST_WIDTH   = 32,
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [INST_WIDTH-1:0] if_rdata,
  input  logic                  mm_req,
  input  logic                  mm_we,
  input  logic [ADDR_WIDTH-1:0] mm_addr,
  input  logic [DATA_WIDTH-1:0] mm_wdata,
  output logic                  mm_gnt,
  output logic                  mm_rvalid,
  output logic [DATA_WIDTH-1:0] mm_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam int unsigned LatW = $clog2(MEM_LATENCY + 1);
  localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [LatW-1:0] LatMax    = LatW'(MEM_LATENCY);
  localparam logic [StW-1:0]  StarveMax = StW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyMm} state_e;

  state_e          state_q, state_d;
  logic [LatW-1:0] lat_cnt_q, lat_cnt_d;
  logic [StW-1:0]  starve_cnt_q, starve_cnt_d;
  logic            cancel_q, cancel_d;
  logic            we_q, we_d;
  // Blocks grants in the first cycle after reset so every output stays low then.
  logic            rst_hold_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      cancel_q     <= 1'b0;
      we_q         <= 1'b0;
      rst_hold_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      cancel_q     <= cancel_d;
      we_q         <= we_d;
      rst_hold_q   <= 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    cancel_d     = cancel_q;
    we_d         = we_q;
    if_gnt       = 1'b0;
    if_rvalid    = 1'b0;
    if_rdata     = '0;
    mm_gnt       = 1'b0;
    mm_rvalid    = 1'b0;
    mm_rdata     = '0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    busy         = 1'b0;

    unique case (state_q)
      StIdle: begin
        cancel_d = 1'b0;
        if (!rst_hold_q) begin
          // A request seen together with a flush carries a stale PC, so it never wins.
          if (if_req && !if_flush && (!mm_req || starve_cnt_q == StarveMax)) begin
            if_gnt       = 1'b1;
            mem_en       = 1'b1;
            mem_addr     = if_addr;
            state_d      = StBusyIf;
            lat_cnt_d    = LatW'(1);
            starve_cnt_d = '0;
          end else if (mm_req) begin
            mm_gnt    = 1'b1;
            mem_en    = 1'b1;
            mem_we    = mm_we;
            mem_addr  = mm_addr;
            mem_wdata = mm_we ? mm_wdata : '0;
            we_d      = mm_we;
            state_d   = StBusyMm;
            lat_cnt_d = LatW'(1);
            if (!if_req) begin
              starve_cnt_d = '0;
            end else if (starve_cnt_q != StarveMax) begin
              starve_cnt_d = starve_cnt_q + StW'(1);
            end
          end else if (!if_req) begin
            starve_cnt_d = '0;
          end
        end
      end
      StBusyIf: begin
        busy = 1'b1;
        if (lat_cnt_q == LatMax) begin
          if (!cancel_q && !if_flush) begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata[INST_WIDTH-1:0];
          end
          state_d   = StIdle;
          lat_cnt_d = '0;
          cancel_d  = 1'b0;
        end else begin
          lat_cnt_d = lat_cnt_q + LatW'(1);
          if (if_flush) begin
            cancel_d = 1'b1;
          end
        end
      end
      StBusyMm: begin
        busy = 1'b1;
        if (lat_cnt_q == LatMax) begin
          mm_rvalid = 1'b1;
          mm_rdata  = we_q ? '0 : mem_rdata;
          state_d   = StIdle;
          lat_cnt_d = '0;
        end else begin
          lat_cnt_d = lat_cnt_q + LatW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (reset) begin
      if_gnt    = 1'b0;
      if_rvalid = 1'b0;
      if_rdata  = '0;
      mm_gnt    = 1'b0;
      mm_rvalid = 1'b0;
      mm_rdata  = '0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      busy      = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios, then randomized traffic checked every cycle
// against a transaction-level model (pending response with a due cycle, integer starvation count).
module tb_mem_port_arbiter;

  localparam int LAT = 2;
  localparam int SL  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [63:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic        mm_req = 1'b0;
  logic        mm_we = 1'b0;
  logic [63:0] mm_addr = '0;
  logic [63:0] mm_wdata = '0;
  logic [63:0] mem_rdata = '0;
  logic        if_gnt, if_rvalid, mm_gnt, mm_rvalid, mem_en, mem_we, busy;
  logic [31:0] if_rdata;
  logic [63:0] mm_rdata, mem_addr, mem_wdata;

  mem_port_arbiter #(
    .ADDR_WIDTH  (64),
    .DATA_WIDTH  (64),
    .INST_WIDTH  (32),
    .MEM_LATENCY (LAT),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_flush (if_flush),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .mm_req   (mm_req),
    .mm_we    (mm_we),
    .mm_addr  (mm_addr),
    .mm_wdata (mm_wdata),
    .mm_gnt   (mm_gnt),
    .mm_rvalid(mm_rvalid),
    .mm_rdata (mm_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Stimulus for the next cycle
  logic        s_reset = 1'b0, s_if_req = 1'b0, s_if_flush = 1'b0, s_mm_req = 1'b0, s_mm_we = 1'b0;
  logic [63:0] s_if_addr = '0, s_mm_addr = '0, s_mm_wdata = '0;

  // Reference model state
  int          cyc = 0;
  bit          pend = 0, pend_if = 0, pend_we = 0, pend_cancel = 0, blk = 0;
  logic [63:0] pend_addr = '0;
  int          pend_due = 0;
  int          starve = 0;
  logic [63:0] mem [logic [63:0]];

  logic        e_if_gnt, e_mm_gnt, e_mem_en, e_mem_we, e_busy, e_if_rvalid, e_mm_rvalid;
  logic [63:0] e_mem_addr, e_mem_wdata, e_mm_rdata;
  logic [31:0] e_if_rdata;

  // Random requester state
  bit          if_hold = 0, mm_hold = 0, mm_we_r = 0;
  logic [63:0] if_a = '0, mm_a = '0, mm_wd = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc - 1);
  endtask

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
  endfunction

  function automatic logic [63:0] rand_addr();
    return 64'({$urandom_range(0, 15), 3'b000});
  endfunction

  task automatic model_eval();
    logic [63:0] rd;
    {e_if_gnt, e_mm_gnt, e_mem_en, e_mem_we, e_busy, e_if_rvalid, e_mm_rvalid} = '0;
    e_mem_addr  = '0;
    e_mem_wdata = '0;
    e_mm_rdata  = '0;
    e_if_rdata  = '0;
    rd = {$urandom, $urandom};
    if (pend && cyc == pend_due) rd = mem_rd(pend_addr);
    mem_rdata = rd;
    if (reset) begin
      pend   = 0;
      starve = 0;
      blk    = 1;
    end else if (pend) begin
      e_busy = 1'b1;
      if (cyc == pend_due) begin
        pend = 0;
        if (pend_if) begin
          if (!pend_cancel && !if_flush) begin
            e_if_rvalid = 1'b1;
            e_if_rdata  = rd[31:0];
          end
        end else begin
          e_mm_rvalid = 1'b1;
          e_mm_rdata  = pend_we ? 64'h0 : rd;
        end
      end else if (pend_if && if_flush) begin
        pend_cancel = 1;
      end
    end else if (blk) begin
      blk = 0;
    end else if (if_req && !if_flush && (!mm_req || starve >= SL)) begin
      e_if_gnt    = 1'b1;
      e_mem_en    = 1'b1;
      e_mem_addr  = if_addr;
      pend        = 1;
      pend_if     = 1;
      pend_we     = 0;
      pend_addr   = if_addr;
      pend_due    = cyc + LAT;
      pend_cancel = 0;
      starve      = 0;
    end else if (mm_req) begin
      e_mm_gnt   = 1'b1;
      e_mem_en   = 1'b1;
      e_mem_we   = mm_we;
      e_mem_addr = mm_addr;
      if (mm_we) begin
        e_mem_wdata   = mm_wdata;
        mem[mm_addr]  = mm_wdata;
      end
      pend        = 1;
      pend_if     = 0;
      pend_we     = mm_we;
      pend_addr   = mm_addr;
      pend_due    = cyc + LAT;
      pend_cancel = 0;
      starve      = if_req ? ((starve + 1 > SL) ? SL : starve + 1) : 0;
    end else if (!if_req) begin
      starve = 0;
    end
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    reset    = s_reset;
    if_req   = s_if_req;
    if_addr  = s_if_addr;
    if_flush = s_if_flush;
    mm_req   = s_mm_req;
    mm_we    = s_mm_we;
    mm_addr  = s_mm_addr;
    mm_wdata = s_mm_wdata;
    model_eval();
    @(negedge clk);
    check("if_gnt",    64'(if_gnt),    64'(e_if_gnt));
    check("mm_gnt",    64'(mm_gnt),    64'(e_mm_gnt));
    check("mem_en",    64'(mem_en),    64'(e_mem_en));
    check("mem_we",    64'(mem_we),    64'(e_mem_we));
    check("mem_addr",  mem_addr,       e_mem_addr);
    check("mem_wdata", mem_wdata,      e_mem_wdata);
    check("busy",      64'(busy),      64'(e_busy));
    check("if_rvalid", 64'(if_rvalid), 64'(e_if_rvalid));
    check("if_rdata",  64'(if_rdata),  64'(e_if_rdata));
    check("mm_rvalid", 64'(mm_rvalid), 64'(e_mm_rvalid));
    check("mm_rdata",  mm_rdata,       e_mm_rdata);
  endtask

  initial begin
    // Reset, then the post-reset cycle in which nothing may be granted
    s_reset = 1'b1;
    step();
    step();
    s_reset = 1'b0;
    step();

    // Plain fetch with a known memory word
    mem[64'h100] = 64'hDEAD_BEEF_0000_0013;
    s_if_req  = 1'b1;
    s_if_addr = 64'h100;
    step();
    check("tp1_if_gnt", 64'(if_gnt), 64'd1);
    check("tp1_mem_addr", mem_addr, 64'h100);
    s_if_req = 1'b0;
    step();
    step();
    check("tp1_if_rvalid", 64'(if_rvalid), 64'd1);
    check("tp1_if_rdata", 64'(if_rdata), 64'h13);

    // Fetch request alongside a flush is not granted; granted once flush drops
    s_if_req   = 1'b1;
    s_if_addr  = 64'h180;
    s_if_flush = 1'b1;
    step();
    check("tp6_no_mem_en", 64'(mem_en), 64'd0);
    s_if_addr  = 64'h1c0;
    s_if_flush = 1'b0;
    step();
    check("tp6_if_gnt", 64'(if_gnt), 64'd1);
    check("tp6_mem_addr", mem_addr, 64'h1c0);
    s_if_req = 1'b0;
    step();
    step();

    // Flush one cycle after grant suppresses the response
    s_if_req  = 1'b1;
    s_if_addr = 64'h40;
    step();
    s_if_req   = 1'b0;
    s_if_flush = 1'b1;
    step();
    check("tp4_busy1", 64'(busy), 64'd1);
    s_if_flush = 1'b0;
    step();
    check("tp4_busy2", 64'(busy), 64'd1);
    check("tp4_no_rvalid", 64'(if_rvalid), 64'd0);

    // Simultaneous requests: data first, fetch three cycles later
    s_if_req   = 1'b1;
    s_if_addr  = 64'h80;
    s_mm_req   = 1'b1;
    s_mm_we    = 1'b0;
    s_mm_addr  = 64'h2000;
    step();
    check("tp2_mm_gnt", 64'(mm_gnt), 64'd1);
    check("tp2_if_wait", 64'(if_gnt), 64'd0);
    s_mm_req = 1'b0;
    step();
    step();
    check("tp2_mm_rvalid", 64'(mm_rvalid), 64'd1);
    step();
    check("tp2_if_gnt", 64'(if_gnt), 64'd1);
    s_if_req = 1'b0;
    step();
    step();
    check("tp2_if_rvalid", 64'(if_rvalid), 64'd1);

    // Reset while a load is in flight: its response never appears
    s_mm_req  = 1'b1;
    s_mm_addr = 64'h2008;
    step();
    s_mm_req = 1'b0;
    s_reset  = 1'b1;
    step();
    s_reset = 1'b0;
    step();
    check("tp5_no_rvalid", 64'(mm_rvalid), 64'd0);
    step();
    s_mm_req = 1'b1;
    step();
    check("tp5_mm_gnt", 64'(mm_gnt), 64'd1);
    s_mm_req = 1'b0;
    step();
    step();

    // Randomized traffic in phases of increasing data-side pressure
    for (int i = 0; i < 3000; i++) begin
      int mm_pct;
      mm_pct = ((i / 500) % 3 == 0) ? 30 : (((i / 500) % 3 == 1) ? 90 : 100);
      s_reset    = ($urandom_range(0, 249) == 0);
      s_if_flush = ($urandom_range(0, 11) == 0);
      if (!if_hold && $urandom_range(0, 99) < 60) begin
        if_hold = 1;
        if_a    = rand_addr();
      end
      if (!mm_hold && $urandom_range(0, 99) < mm_pct) begin
        mm_hold = 1;
        mm_we_r = 1'($urandom_range(0, 1));
        mm_a    = rand_addr();
        mm_wd   = {$urandom, $urandom};
      end
      s_if_req   = if_hold;
      s_if_addr  = if_a;
      s_mm_req   = mm_hold;
      s_mm_we    = mm_we_r;
      s_mm_addr  = mm_a;
      s_mm_wdata = mm_wd;
      step();
      if (e_if_gnt) if_hold = 0;
      if (e_mm_gnt) mm_hold = 0;
      if (s_if_flush && if_hold) if_a = rand_addr();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
